// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// Feeds the hex display so a binary value is shown as decimal digits.
module bin2bcd_seq #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [WIDTH-1:0]    i_data,
   input  logic                i_valid,
   output logic                o_ready,
   output logic [4*DIGITS-1:0] o_bcd,
   output logic                o_ovf,
   output logic                o_done
);

   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q;
   logic [WIDTH-1:0]   bin_q;
   logic [BCD_W-1:0]   bcd_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               ovf_q;

   logic [BCD_W-1:0]   bcd_adj;
   logic [BCD_W-1:0]   bcd_nxt;
   logic [WIDTH-1:0]   bin_nxt;
   logic               ovf_bit;

   assign o_ready = (state_q == IDLE);

   // Add-3 on every digit >= 5, then shift one binary bit into the BCD register.
   always_comb begin
      bcd_adj = bcd_q;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (bcd_q[4*k +: 4] >= 4'd5) begin
            bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
         end
      end
      bcd_nxt = {bcd_adj[BCD_W-2:0], bin_q[WIDTH-1]};
      bin_nxt = {bin_q[WIDTH-2:0], 1'b0};
      // Anything leaving the top digit means the value needs more than DIGITS digits.
      ovf_bit = bcd_adj[BCD_W-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         o_bcd   <= '0;
         o_ovf   <= 1'b0;
         o_done  <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state_q)
            IDLE: begin
               if (i_valid) begin
                  bin_q   <= i_data;
                  bcd_q   <= '0;
                  ovf_q   <= 1'b0;
                  cnt_q   <= CNT_W'(WIDTH);
                  state_q <= CONV;
               end
            end
            CONV: begin
               bin_q <= bin_nxt;
               bcd_q <= bcd_nxt;
               ovf_q <= ovf_q | ovf_bit;
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               o_bcd   <= bcd_q;
               o_ovf   <= ovf_q;
               o_done  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: accepts push decimal-arithmetic expectations,
// a monitor pops and compares on every o_done.
module tb_bin2bcd_seq;

   localparam int unsigned WIDTH  = 16;
   localparam int unsigned DIGITS = 4;
   localparam int unsigned LAT    = WIDTH + 1;

   logic                clk;
   logic                rst_n;
   logic [WIDTH-1:0]    i_data;
   logic                i_valid;
   logic                o_ready;
   logic [4*DIGITS-1:0] o_bcd;
   logic                o_ovf;
   logic                o_done;

   bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_data (i_data),
      .i_valid(i_valid),
      .o_ready(o_ready),
      .o_bcd  (o_bcd),
      .o_ovf  (o_ovf),
      .o_done (o_done)
   );

   typedef struct {
      logic [15:0] bcd;
      logic        ovf;
      int unsigned acc;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned acc_hist[$];
   int unsigned cyc     = 0;
   int          total   = 0;
   int          bad     = 0;
   int          n_push  = 0;
   int          n_done  = 0;
   int          n_abort = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: plain decimal arithmetic on the integer value.
   function automatic logic [15:0] ref_bcd(input int unsigned v);
      int unsigned m;
      logic [15:0] r;
      m = v % 10000;
      r = '0;
      for (int k = 0; k < 4; k++) begin
         r[4*k +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Accept observer: the edge that takes a request pushes its expectation.
   always @(posedge clk) begin
      if (rst_n && i_valid && o_ready) begin
         exp_t e;
         e.bcd = ref_bcd(32'(i_data));
         e.ovf = (32'(i_data) >= 10000);
         e.acc = cyc + 1;
         exp_q.push_back(e);
         acc_hist.push_back(cyc + 1);
         n_push++;
      end
   end

   // Result monitor.
   always @(negedge clk) begin
      if (rst_n && o_done) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got o_done=1 expected no pending request (t=%0t)", $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            n_done++;
            check("bcd", 32'(o_bcd), 32'(e.bcd));
            check("ovf", 32'(o_ovf), 32'(e.ovf));
            check("latency", cyc - e.acc, LAT);
         end
      end
   end

   // Present a request and return at the negedge after it is accepted.
   task automatic send(input logic [WIDTH-1:0] v, input bit hold);
      int n = 0;
      i_data  = v;
      i_valid = 1'b1;
      while (!o_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!o_ready) check("accept_timeout", 32'(o_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      if (!hold) i_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || !o_ready) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish before timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int unsigned base;
      rst_n   = 1'b0;
      i_valid = 1'b0;
      i_data  = '0;
      #12;
      check("rst_bcd",   32'(o_bcd),   32'd0);
      check("rst_ovf",   32'(o_ovf),   32'd0);
      check("rst_done",  32'(o_done),  32'd0);
      check("rst_ready", 32'(o_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      send(16'd0, 1'b0);
      drain();

      // o_ready must stay low for exactly LAT sampled cycles after the accept.
      send(16'd1234, 1'b0);
      n = 0;
      while (!o_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      check("ready_low_cycles", 32'(n), LAT);
      drain();

      send(16'd9999, 1'b0);
      send(16'd10000, 1'b0);
      send(16'd65535, 1'b0);
      drain();

      // Back-to-back with i_valid held and i_data changed while busy.
      base = acc_hist.size();
      send(16'd42, 1'b1);
      i_data = 16'd7;
      n = 0;
      while (acc_hist.size() < base + 2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      i_valid = 1'b0;
      if (acc_hist.size() >= base + 2)
         check("b2b_spacing", acc_hist[base+1] - acc_hist[base], LAT + 1);
      else
         check("b2b_second_accept", 32'(acc_hist.size()), 32'(base + 2));
      drain();

      // Asynchronous reset in the middle of a conversion.
      send(16'd4321, 1'b0);
      repeat (8) @(posedge clk);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      n_abort++;
      #1;
      check("midrst_bcd",   32'(o_bcd),   32'd0);
      check("midrst_ovf",   32'(o_ovf),   32'd0);
      check("midrst_done",  32'(o_done),  32'd0);
      check("midrst_ready", 32'(o_ready), 32'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(16'd4321, 1'b0);
      drain();

      // Random sweep with i_data scrambled while busy.
      for (int i = 0; i < 1000; i++) begin
         send(WIDTH'($urandom_range(0, 65535)), 1'b0);
         i_data = WIDTH'($urandom);
      end
      drain();

      check("done_count", 32'(n_done), 32'(n_push - n_abort));
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
